// File: rtl/iob_im_sprite_pkg.sv
// Register map, attribute field positions and the sprite hit rule shared by the sprite engine.
package iob_im_sprite_pkg;
  localparam int unsigned REG_LOC  = 0;
  localparam int unsigned REG_ATTR = 1;
  // BG/COL/FCNT offsets are relative to 2*N_SPR
  localparam int unsigned REG_BG   = 0;
  localparam int unsigned REG_COL  = 1;
  localparam int unsigned REG_FCNT = 2;

  localparam int unsigned ATTR_EN_BIT  = 31;
  localparam int unsigned ATTR_COL_LSB = 16;
  localparam int unsigned ATTR_HY_LSB  = 8;
  localparam int unsigned ATTR_HX_LSB  = 0;

  localparam int unsigned HIT_CW = 16;
  localparam int unsigned HIT_HW = 8;
  localparam int unsigned HIT_DW = HIT_CW + 1;

  // Signed differences one bit wider than the coordinates, so a sprite near 0 clips instead of wrapping
  function automatic logic sprite_hit(
    input logic [HIT_CW-1:0] px,
    input logic [HIT_CW-1:0] py,
    input logic [HIT_CW-1:0] x,
    input logic [HIT_CW-1:0] y,
    input logic [HIT_HW-1:0] hx,
    input logic [HIT_HW-1:0] hy
  );
    logic signed [HIT_DW-1:0] dx;
    logic signed [HIT_DW-1:0] dy;
    logic signed [HIT_DW-1:0] lim_x;
    logic signed [HIT_DW-1:0] lim_y;
    dx = $signed({1'b0, px}) - $signed({1'b0, x});
    dy = $signed({1'b0, py}) - $signed({1'b0, y});
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    lim_x = $signed(HIT_DW'(hx));
    lim_y = $signed(HIT_DW'(hy));
    return (dx <= lim_x) && (dy <= lim_y);
  endfunction
endpackage

// File: rtl/iob_im_sprite_hit.sv
// Combinational range test of one sprite against the current pixel.
module iob_im_sprite_hit
  import iob_im_sprite_pkg::*;
#(
  parameter int unsigned COORD_W = 10,
  parameter int unsigned HALF_W  = 8
) (
  input  logic               en,
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [HALF_W-1:0]  hx,
  input  logic [HALF_W-1:0]  hy,
  output logic               hit_c
);
  assign hit_c = en && sprite_hit(HIT_CW'(px), HIT_CW'(py), HIT_CW'(x), HIT_CW'(y),
                                  HIT_HW'(hx), HIT_HW'(hy));
endmodule

// File: rtl/iob_im_sprite_engine.sv
// Composites N_SPR double-buffered rectangular sprites over a background colour,
// with per-frame collision flags and a 2-cycle pixel pipeline.
module iob_im_sprite_engine
  import iob_im_sprite_pkg::*;
#(
  parameter int unsigned N_SPR   = 4,
  parameter int unsigned COORD_W = 10,
  parameter int unsigned HALF_W  = 8,
  parameter int unsigned RGB_W   = 12,
  parameter int unsigned ADDR_W  = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               frame_sof,
  output logic               rgb_valid,
  output logic [RGB_W-1:0]   rgb
);
  localparam int unsigned LOC_W  = 2 * COORD_W;
  localparam int unsigned A_BG   = 2 * N_SPR + REG_BG;
  localparam int unsigned A_COL  = 2 * N_SPR + REG_COL;
  localparam int unsigned A_FCNT = 2 * N_SPR + REG_FCNT;

  logic [COORD_W-1:0] x_sh  [N_SPR];
  logic [COORD_W-1:0] y_sh  [N_SPR];
  logic [HALF_W-1:0]  hx_sh [N_SPR];
  logic [HALF_W-1:0]  hy_sh [N_SPR];
  logic [RGB_W-1:0]   col_sh[N_SPR];
  logic [N_SPR-1:0]   en_sh;
  logic [RGB_W-1:0]   bg_sh;

  logic [COORD_W-1:0] x_act  [N_SPR];
  logic [COORD_W-1:0] y_act  [N_SPR];
  logic [HALF_W-1:0]  hx_act [N_SPR];
  logic [HALF_W-1:0]  hy_act [N_SPR];
  logic [RGB_W-1:0]   col_act[N_SPR];
  logic [N_SPR-1:0]   en_act;
  logic [RGB_W-1:0]   bg_act;

  logic [N_SPR-1:0] hit_c;
  logic [N_SPR-1:0] hit_v_c;
  logic             multi_c;
  logic [N_SPR-1:0] s1_hit;
  logic             s1_valid;
  logic [RGB_W-1:0] pix_c;
  logic [N_SPR-1:0] col_acc;
  logic [N_SPR-1:0] col_status;
  logic [31:0]      frame_cnt;
  logic [31:0]      rdata_c;
  logic             unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  for (genvar g = 0; g < N_SPR; g++) begin : g_hit
    iob_im_sprite_hit #(.COORD_W(COORD_W), .HALF_W(HALF_W)) u_hit (
      .en(en_act[g]), .px(pix_x), .py(pix_y), .x(x_act[g]), .y(y_act[g]),
      .hx(hx_act[g]), .hy(hy_act[g]), .hit_c(hit_c[g])
    );
  end

  assign hit_v_c = pix_valid ? hit_c : '0;
  // Clearing the lowest set bit leaves something only when two or more sprites hit
  assign multi_c = |(hit_v_c & (hit_v_c - N_SPR'(1)));

  always_comb begin
    rdata_c = '0;
    for (int i = 0; i < int'(N_SPR); i++) begin
      if (cfg_addr == ADDR_W'(2 * i + REG_LOC)) rdata_c = 32'({y_sh[i], x_sh[i]});
      if (cfg_addr == ADDR_W'(2 * i + REG_ATTR)) begin
        rdata_c[ATTR_EN_BIT]                = en_sh[i];
        rdata_c[ATTR_COL_LSB +: RGB_W]      = col_sh[i];
        rdata_c[ATTR_HY_LSB +: HALF_W]      = hy_sh[i];
        rdata_c[ATTR_HX_LSB +: HALF_W]      = hx_sh[i];
      end
    end
    if (cfg_addr == ADDR_W'(A_BG))   rdata_c = 32'(bg_sh);
    if (cfg_addr == ADDR_W'(A_COL))  rdata_c = 32'(col_status);
    if (cfg_addr == ADDR_W'(A_FCNT)) rdata_c = frame_cnt;
  end

  // Shadow bank and registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_SPR); i++) begin
        x_sh[i] <= '0; y_sh[i] <= '0; hx_sh[i] <= '0; hy_sh[i] <= '0; col_sh[i] <= '0;
      end
      en_sh     <= '0;
      bg_sh     <= '0;
      cfg_rdata <= '0;
    end else begin
      cfg_rdata <= rdata_c;
      if (cfg_we) begin
        for (int i = 0; i < int'(N_SPR); i++) begin
          if (cfg_addr == ADDR_W'(2 * i + REG_LOC)) begin
            x_sh[i] <= cfg_wdata[COORD_W-1:0];
            y_sh[i] <= cfg_wdata[LOC_W-1:COORD_W];
          end
          if (cfg_addr == ADDR_W'(2 * i + REG_ATTR)) begin
            en_sh[i]  <= cfg_wdata[ATTR_EN_BIT];
            col_sh[i] <= cfg_wdata[ATTR_COL_LSB +: RGB_W];
            hy_sh[i]  <= cfg_wdata[ATTR_HY_LSB +: HALF_W];
            hx_sh[i]  <= cfg_wdata[ATTR_HX_LSB +: HALF_W];
          end
        end
        if (cfg_addr == ADDR_W'(A_BG)) bg_sh <= cfg_wdata[RGB_W-1:0];
      end
    end
  end

  // Active bank takes the pre-edge shadow on frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_SPR); i++) begin
        x_act[i] <= '0; y_act[i] <= '0; hx_act[i] <= '0; hy_act[i] <= '0; col_act[i] <= '0;
      end
      en_act <= '0;
      bg_act <= '0;
    end else if (frame_sof) begin
      x_act   <= x_sh;
      y_act   <= y_sh;
      hx_act  <= hx_sh;
      hy_act  <= hy_sh;
      col_act <= col_sh;
      en_act  <= en_sh;
      bg_act  <= bg_sh;
    end
  end

  // Collision accumulation; a colliding pixel on the frame-start cycle belongs to the new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_acc    <= '0;
      col_status <= '0;
      frame_cnt  <= '0;
    end else begin
      if (frame_sof) begin
        col_status <= col_acc;
        col_acc    <= multi_c ? hit_v_c : '0;
        frame_cnt  <= frame_cnt + 32'd1;
      end else if (multi_c) begin
        col_acc <= col_acc | hit_v_c;
      end
    end
  end

  always_comb begin
    pix_c = bg_act;
    for (int i = int'(N_SPR) - 1; i >= 0; i--) begin
      if (s1_hit[i]) pix_c = col_act[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_hit    <= '0;
      rgb_valid <= 1'b0;
      rgb       <= '0;
    end else begin
      s1_valid  <= pix_valid;
      s1_hit    <= hit_v_c;
      rgb_valid <= s1_valid;
      rgb       <= s1_valid ? pix_c : '0;
    end
  end
endmodule

// File: tb/tb_iob_im_sprite_engine.sv
// Self-checking bench for iob_im_sprite_engine against a frame-level behavioural model.
module tb_iob_im_sprite_engine;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        frame_sof;
  logic        rgb_valid;
  logic [11:0] rgb;

  iob_im_sprite_engine dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .frame_sof(frame_sof), .rgb_valid(rgb_valid), .rgb(rgb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: shadow and active sprite tables, collision and frame state
  int s_x[N], s_y[N], s_hx[N], s_hy[N], s_col[N];
  int a_x[N], a_y[N], a_hx[N], a_hy[N], a_col[N];
  bit s_en[N], a_en[N];
  int s_bg, a_bg;
  logic [3:0]  m_acc, m_status;
  logic [31:0] m_fcnt;

  logic        exp_v1;
  logic [11:0] exp_rgb1;
  logic        got_v, want_v;
  logic [11:0] got_rgb, want_rgb;
  logic [31:0] got_rd, want_rd;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      s_x[i] = 0; s_y[i] = 0; s_hx[i] = 0; s_hy[i] = 0; s_col[i] = 0; s_en[i] = 0;
      a_x[i] = 0; a_y[i] = 0; a_hx[i] = 0; a_hy[i] = 0; a_col[i] = 0; a_en[i] = 0;
    end
    s_bg = 0; a_bg = 0; m_acc = 0; m_status = 0; m_fcnt = 0;
    exp_v1 = 0; exp_rgb1 = 0;
  endfunction

  function automatic void model_write(int addr, logic [31:0] d);
    if (addr < 2 * N) begin
      if (addr % 2 == 0) begin
        s_x[addr/2] = int'(d[9:0]);
        s_y[addr/2] = int'(d[19:10]);
      end else begin
        s_en[addr/2]  = d[31];
        s_col[addr/2] = int'(d[27:16]);
        s_hy[addr/2]  = int'(d[15:8]);
        s_hx[addr/2]  = int'(d[7:0]);
      end
    end else if (addr == 2 * N) begin
      s_bg = int'(d[11:0]);
    end
  endfunction

  function automatic logic [31:0] model_read(int addr);
    logic [31:0] r;
    r = 0;
    if (addr < 2 * N) begin
      if (addr % 2 == 0) r = (32'(s_y[addr/2]) << 10) | 32'(s_x[addr/2]);
      else r = (32'(s_en[addr/2]) << 31) | (32'(s_col[addr/2]) << 16) |
               (32'(s_hy[addr/2]) << 8) | 32'(s_hx[addr/2]);
    end else if (addr == 2 * N) r = 32'(s_bg);
    else if (addr == 2 * N + 1) r = 32'(m_status);
    else if (addr == 2 * N + 2) r = m_fcnt;
    return r;
  endfunction

  function automatic logic [3:0] model_hits(int px, int py);
    logic [3:0] h;
    h = 0;
    for (int i = 0; i < N; i++) begin
      int dx, dy;
      dx = px - a_x[i]; if (dx < 0) dx = -dx;
      dy = py - a_y[i]; if (dy < 0) dy = -dy;
      if (a_en[i] && dx <= a_hx[i] && dy <= a_hy[i]) h[i] = 1'b1;
    end
    return h;
  endfunction

  function automatic logic [11:0] model_colour(logic [3:0] h);
    for (int i = 0; i < N; i++) if (h[i]) return 12'(a_col[i]);
    return 12'(a_bg);
  endfunction

  // One clock: update the model as of this edge, then sample the DUT just after it
  task automatic tick();
    logic [3:0]  h;
    logic        cur_v;
    logic [11:0] cur_rgb;
    logic [31:0] rd_next;
    h       = pix_valid ? model_hits(int'(pix_x), int'(pix_y)) : 4'd0;
    cur_v   = pix_valid;
    cur_rgb = pix_valid ? model_colour(h) : 12'd0;
    rd_next = model_read(int'(cfg_addr));
    if (frame_sof) begin
      m_status = m_acc;
      m_acc    = 0;
      m_fcnt   = m_fcnt + 1;
      a_x = s_x; a_y = s_y; a_hx = s_hx; a_hy = s_hy; a_col = s_col; a_en = s_en; a_bg = s_bg;
    end
    if ($countones(h) >= 2) m_acc = m_acc | h;
    if (cfg_we) model_write(int'(cfg_addr), cfg_wdata);
    @(posedge clk); #1;
    got_v = rgb_valid; got_rgb = rgb; want_v = exp_v1; want_rgb = exp_rgb1;
    exp_v1 = cur_v; exp_rgb1 = cur_rgb;
    got_rd = cfg_rdata; want_rd = rd_next;
    cfg_we = 1'b0;
    frame_sof = 1'b0;
  endtask

  task automatic wr(int addr, logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = 6'(addr); cfg_wdata = d; pix_valid = 1'b0;
    tick();
  endtask

  task automatic rd(int addr);
    cfg_we = 1'b0; cfg_addr = 6'(addr); pix_valid = 1'b0;
    tick();
  endtask

  task automatic sof();
    frame_sof = 1'b1; pix_valid = 1'b0;
    tick();
  endtask

  task automatic pix(int px, int py);
    pix_valid = 1'b1; pix_x = 10'(px); pix_y = 10'(py);
    tick();
  endtask

  task automatic idle();
    pix_valid = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] attr(int en, int col, int hy, int hx);
    return (32'(en) << 31) | (32'(col) << 16) | (32'(hy) << 8) | 32'(hx);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; pix_valid = 0; pix_x = 0; pix_y = 0;
    frame_sof = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rgb_valid, rgb, cfg_rdata} !== 45'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b rgb=%h rd=%h want all 0", rgb_valid, rgb, cfg_rdata);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      pix_valid = 1'($urandom_range(0, 1));
      pix_x = 10'($urandom); pix_y = 10'($urandom);
      tick();
      checks++;
      if ({got_v, got_rgb} !== {want_v, 12'd0}) begin
        errors++;
        $display("FAIL no_commit_stream k=%0d got v=%b rgb=%h want v=%b rgb=000", k, got_v, got_rgb, want_v);
      end
    end
    idle();
  endtask

  task automatic test_single_sprite();
    bit pv;
    int ppx, ppy;
    logic [11:0] cexp;
    wr(0, (32'd100 << 10) | 32'd100);
    wr(1, attr(1, 'hF00, 2, 2));
    wr(8, 32'h00F);
    sof();
    pix(97, 100);
    pix(100, 100);
    checks++;
    if (got_rgb !== 12'h00F) begin errors++; $display("FAIL left_edge got %h want 00f", got_rgb); end
    pix(103, 100);
    checks++;
    if (got_rgb !== 12'hF00) begin errors++; $display("FAIL centre got %h want f00", got_rgb); end
    idle();
    checks++;
    if (got_rgb !== 12'h00F) begin errors++; $display("FAIL right_edge got %h want 00f", got_rgb); end
    pv = 0; ppx = 0; ppy = 0;
    for (int y = 96; y <= 104; y++) begin
      for (int x = 96; x <= 104; x++) begin
        pix(x, y);
        cexp = (ppx >= 98 && ppx <= 102 && ppy >= 98 && ppy <= 102) ? 12'hF00 : 12'h00F;
        checks++;
        if ({got_v, got_rgb} !== {want_v, want_rgb} || (pv && got_rgb !== cexp)) begin
          errors++;
          $display("FAIL box_scan (%0d,%0d) got v=%b rgb=%h want v=%b rgb=%h", ppx, ppy, got_v, got_rgb, want_v, want_rgb);
        end
        pv = 1; ppx = x; ppy = y;
      end
    end
    idle();
  endtask

  task automatic test_clip();
    wr(0, (32'd1 << 10) | 32'd1);
    wr(1, attr(1, 'hABC, 3, 3));
    sof();
    pix(0, 0);
    pix(639, 479);
    checks++;
    if (got_rgb !== 12'hABC) begin errors++; $display("FAIL clip_origin got %h want abc", got_rgb); end
    idle();
    checks++;
    if (got_rgb !== 12'h00F) begin errors++; $display("FAIL no_wrap got %h want 00f", got_rgb); end
  endtask

  task automatic test_collision();
    wr(0, (32'd200 << 10) | 32'd200);
    wr(1, attr(1, 'h0F0, 2, 2));
    wr(3, 0);
    wr(4, (32'd202 << 10) | 32'd202);
    wr(5, attr(1, 'hFFF, 2, 2));
    sof();
    pix(201, 201);
    pix(190, 190);
    checks++;
    if (got_rgb !== 12'h0F0 || want_rgb !== 12'h0F0) begin
      errors++; $display("FAIL overlap_priority got %h want 0f0", got_rgb);
    end
    idle();
    sof();
    rd(9);
    checks++;
    if (got_rd !== 32'h5 || want_rd !== 32'h5) begin errors++; $display("FAIL col_status_hit got %h want 5", got_rd); end
    pix(198, 198);
    idle();
    sof();
    rd(9);
    checks++;
    if (got_rd !== 32'h0) begin errors++; $display("FAIL col_status_clear got %h want 0", got_rd); end
    frame_sof = 1'b1;
    pix(201, 201);
    checks++;
    if ({got_v, got_rgb} !== {want_v, want_rgb}) begin
      errors++; $display("FAIL sof_pixel_rgb got %h want %h", got_rgb, want_rgb);
    end
    rd(9);
    checks++;
    if (got_rd !== 32'h0) begin errors++; $display("FAIL sof_collision_old_frame got %h want 0", got_rd); end
    sof();
    rd(9);
    checks++;
    if (got_rd !== 32'h5) begin errors++; $display("FAIL sof_collision_new_frame got %h want 5", got_rd); end
  endtask

  task automatic test_sof_write();
    wr(5, 0);
    sof();
    frame_sof = 1'b1; cfg_we = 1'b1; cfg_addr = 6'd0; cfg_wdata = (32'd300 << 10) | 32'd300;
    pix_valid = 1'b0;
    tick();
    pix(200, 200);
    pix(300, 300);
    checks++;
    if (got_rgb !== 12'h0F0) begin errors++; $display("FAIL old_pos_drawn got %h want 0f0", got_rgb); end
    idle();
    checks++;
    if (got_rgb !== 12'h00F) begin errors++; $display("FAIL new_pos_early got %h want 00f", got_rgb); end
    rd(0);
    checks++;
    if (got_rd !== ((32'd300 << 10) | 32'd300)) begin
      errors++; $display("FAIL loc0_readback got %h want %h", got_rd, (32'd300 << 10) | 32'd300);
    end
    sof();
    pix(200, 200);
    pix(300, 300);
    checks++;
    if (got_rgb !== 12'h00F) begin errors++; $display("FAIL old_pos_gone got %h want 00f", got_rgb); end
    idle();
    checks++;
    if (got_rgb !== 12'h0F0) begin errors++; $display("FAIL new_pos_drawn got %h want 0f0", got_rgb); end
  endtask

  task automatic test_random();
    int a;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) begin
        wr(2 * i, (32'($urandom_range(20, 60)) << 10) | 32'($urandom_range(20, 60)));
        wr(2 * i + 1, attr(($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 4095)),
                           int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
      end
      wr(8, 32'($urandom_range(0, 4095)));
      sof();
      for (int k = 0; k < 120; k++) begin
        pix_valid = ($urandom_range(0, 4) != 0);
        pix_x = 10'($urandom_range(10, 70)); pix_y = 10'($urandom_range(10, 70));
        if ($urandom_range(0, 3) == 0) begin
          cfg_we = 1'b1; cfg_addr = 6'($urandom); cfg_wdata = $urandom;
        end
        tick();
        checks++;
        if ({got_v, got_rgb} !== {want_v, want_rgb}) begin
          errors++;
          $display("FAIL random_pix r=%0d k=%0d got v=%b rgb=%h want v=%b rgb=%h", r, k, got_v, got_rgb, want_v, want_rgb);
        end
      end
      idle();
      sof();
      rd(9);
      checks++;
      if (got_rd !== want_rd) begin errors++; $display("FAIL random_col r=%0d got %h want %h", r, got_rd, want_rd); end
      for (int k = 0; k < 4; k++) begin
        a = int'($urandom_range(0, 63));
        rd(a);
        checks++;
        if (got_rd !== want_rd) begin errors++; $display("FAIL random_read a=%0d got %h want %h", a, got_rd, want_rd); end
      end
      rd(10);
      checks++;
      if (got_rd !== want_rd) begin errors++; $display("FAIL frame_cnt got %h want %h", got_rd, want_rd); end
    end
  endtask

  task automatic test_reset_mid();
    wr(0, (32'd50 << 10) | 32'd50);
    wr(1, attr(1, 'h123, 5, 5));
    sof();
    pix(50, 50);
    pix(51, 50);
    checks++;
    if ({got_v, got_rgb} !== {1'b1, 12'h123}) begin
      errors++; $display("FAIL pre_reset_draw got v=%b rgb=%h want v=1 rgb=123", got_v, got_rgb);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rgb_valid, rgb} !== 13'd0) begin
      errors++; $display("FAIL async_reset got v=%b rgb=%h want 0", rgb_valid, rgb);
    end
    pix_valid = 1'b0; cfg_we = 1'b0; frame_sof = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    rd(10);
    checks++;
    if (got_rd !== 32'd0) begin errors++; $display("FAIL reset_frame_cnt got %h want 0", got_rd); end
    rd(9);
    checks++;
    if (got_rd !== 32'd0) begin errors++; $display("FAIL reset_col_status got %h want 0", got_rd); end
    for (int k = 0; k < 10; k++) begin
      pix(int'($urandom_range(45, 55)), int'($urandom_range(45, 55)));
      checks++;
      if ({got_v, got_rgb} !== {want_v, want_rgb} || got_rgb !== 12'd0) begin
        errors++; $display("FAIL post_reset_blank k=%0d got %h want 000", k, got_rgb);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_sprite();
    test_clip();
    test_collision();
    test_sof_write();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
